// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions: opcodes, ALU encodings, bundle layout.
package riscv_pkg;

  localparam int DE_BUNDLE_W = 294;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_e;

  // Bundle field positions (lsb of each multi-bit field, or the bit itself)
  localparam int BP_PC        = 230;
  localparam int BP_RS1_DATA  = 166;
  localparam int BP_RS2_DATA  = 102;
  localparam int BP_IMM       = 38;
  localparam int BP_RD        = 33;
  localparam int BP_RS1       = 28;
  localparam int BP_RS2       = 23;
  localparam int BP_REG_WRITE = 22;
  localparam int BP_MEM_READ  = 21;
  localparam int BP_MEM_WRITE = 20;
  localparam int BP_MEM_TO_REG = 19;
  localparam int BP_BRANCH    = 18;
  localparam int BP_JAL       = 17;
  localparam int BP_JALR      = 16;
  localparam int BP_ALU_SRC   = 15;
  localparam int BP_LUI       = 14;
  localparam int BP_AUIPC     = 13;
  localparam int BP_ALU_CTRL  = 9;
  localparam int BP_FUNCT3    = 6;
  localparam int BP_WORD_OP   = 1;
  localparam int BP_VALID     = 0;

  // Field order matches the bit positions above, msb first
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        alu_src;
    logic        lui;
    logic        auipc;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic [3:0]  reserved;
    logic        word_op;
    logic        valid;
  } de_bundle_t;

  // alt selects SUB/SRA (instr[30]) for the two funct3 codes that have an alternate form
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write architectural register file with writeback bypass; x0 reads as zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  // Writes are ignored while reset is held and never land in x0
  assign wr_en = rst_n && we && (waddr != '0);

  // Next-state of the array: one entry updated per cycle
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  // Array storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads with same-cycle bypass from the write port
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
    if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode: control decode, immediate generation, load-use hazard and register read.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            if_instr,
  input  logic [XLEN-1:0]        if_pc,
  input  logic                   if_valid,
  input  logic                   wb_reg_write,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_valid,
  input  logic                   branch_flush,
  output logic [DE_BUNDLE_W-1:0] de_bundle,
  output logic                   stall,
  output logic                   illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [4:0]      rs1_idx, rs2_idx;
  logic            legal, use_rs1, use_rs2, has_rd, has_f3;
  logic            load_use, bubble;
  de_bundle_t      ctl, bundle;

  assign opcode = if_instr[6:0];
  assign f3     = if_instr[14:12];
  assign f7     = if_instr[31:25];
  assign rd_f   = if_instr[11:7];
  assign rs1_f  = if_instr[19:15];
  assign rs2_f  = if_instr[24:20];

  assign imm_i = {{52{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{52{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{51{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {{32{if_instr[31]}}, if_instr[31:12], 12'b0};
  assign imm_j = {{43{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Main control decode: control bits, immediate and operand usage per opcode
  always_comb begin
    ctl     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    has_f3  = 1'b1;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; has_rd = 1'b1; has_f3 = 1'b0;
        ctl.lui = 1'b1; ctl.alu_src = 1'b1; ctl.alu_ctrl = ALU_PASS_B; ctl.imm = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1; has_rd = 1'b1; has_f3 = 1'b0;
        ctl.auipc = 1'b1; ctl.alu_src = 1'b1; ctl.alu_ctrl = ALU_ADD; ctl.imm = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; has_rd = 1'b1; has_f3 = 1'b0;
        ctl.jal = 1'b1; ctl.alu_ctrl = ALU_ADD; ctl.imm = imm_j;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); has_rd = 1'b1; use_rs1 = 1'b1;
        ctl.jalr = 1'b1; ctl.alu_src = 1'b1; ctl.alu_ctrl = ALU_ADD; ctl.imm = imm_i;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctl.branch = 1'b1; ctl.alu_ctrl = ALU_SUB; ctl.imm = imm_b;
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b111); has_rd = 1'b1; use_rs1 = 1'b1;
        ctl.mem_read = 1'b1; ctl.mem_to_reg = 1'b1; ctl.alu_src = 1'b1;
        ctl.alu_ctrl = ALU_ADD; ctl.imm = imm_i;
      end
      OPC_STORE: begin
        legal = (f3[2] == 1'b0); use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctl.mem_write = 1'b1; ctl.alu_src = 1'b1; ctl.alu_ctrl = ALU_ADD; ctl.imm = imm_s;
      end
      OPC_OP_IMM: begin
        has_rd = 1'b1; use_rs1 = 1'b1; ctl.alu_src = 1'b1; ctl.imm = imm_i;
        ctl.alu_ctrl = alu_from_f3(f3, (f3 == 3'b101) && if_instr[30]);
        case (f3)
          3'b001:  legal = (if_instr[31:26] == 6'b000000);
          3'b101:  legal = (if_instr[31:26] == 6'b000000) || (if_instr[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
        // 6-bit shift amount; drops the SRAI selector bit from the immediate
        if (f3 == 3'b001 || f3 == 3'b101) ctl.imm = {58'b0, if_instr[25:20]};
      end
      OPC_OP: begin
        has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctl.alu_ctrl = alu_from_f3(f3, if_instr[30]);
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OP_IMM_32: begin
        has_rd = 1'b1; use_rs1 = 1'b1; ctl.alu_src = 1'b1; ctl.word_op = 1'b1;
        ctl.alu_ctrl = alu_from_f3(f3, (f3 == 3'b101) && if_instr[30]);
        ctl.imm = imm_i;
        case (f3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b0;
        endcase
        // 5-bit shift amount for the word forms
        if (f3 == 3'b001 || f3 == 3'b101) ctl.imm = {59'b0, if_instr[24:20]};
      end
      OPC_OP_32: begin
        has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; ctl.word_op = 1'b1;
        ctl.alu_ctrl = alu_from_f3(f3, if_instr[30]);
        case (f3)
          3'b000, 3'b101: legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          3'b001:         legal = (f7 == 7'b0000000);
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
    ctl.reg_write = has_rd;
  end

  assign rs1_idx = use_rs1 ? rs1_f : 5'd0;
  assign rs2_idx = use_rs2 ? rs2_f : 5'd0;

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst_n  (reset_n),
    .we     (wb_reg_write),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // Hazard and bubble qualification; flush overrides both stall and illegal
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((use_rs1 && ex_rd == rs1_f) || (use_rs2 && ex_rd == rs2_f));
    stall    = reset_n && if_valid && !branch_flush && load_use;
    illegal  = reset_n && if_valid && !branch_flush && !legal;
    bubble   = !reset_n || !if_valid || branch_flush || stall || illegal;
  end

  // Bundle assembly: pc always passes, everything else only for a live instruction
  always_comb begin
    bundle    = '0;
    bundle.pc = if_pc;
    if (!bubble) begin
      bundle          = ctl;
      bundle.pc       = if_pc;
      bundle.rs1_data = rs1_data;
      bundle.rs2_data = rs2_data;
      bundle.rd       = has_rd ? rd_f : 5'd0;
      bundle.rs1      = rs1_idx;
      bundle.rs2      = rs2_idx;
      bundle.funct3   = has_f3 ? f3 : 3'd0;
      bundle.reserved = 4'd0;
      bundle.valid    = 1'b1;
    end
  end

  assign de_bundle = bundle;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  if_instr;
  logic [63:0]  if_pc;
  logic         if_valid;
  logic         wb_reg_write;
  logic [4:0]   wb_rd;
  logic [63:0]  wb_data;
  logic         ex_mem_read;
  logic [4:0]   ex_rd;
  logic         ex_valid;
  logic         branch_flush;
  logic [293:0] de_bundle;
  logic         stall;
  logic         illegal;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_valid     (ex_valid),
    .branch_flush (branch_flush),
    .de_bundle    (de_bundle),
    .stall        (stall),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_instr = 32'h0031_8233; if_pc = 64'h1000; if_valid = 1'b1;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_valid = 1'b0; branch_flush = 1'b0;

    // Reset: write to x5 attempted, decode add x4,x5,x5
    if_instr = 32'h0052_8233;
    #2;
    chk("rst_valid", {63'b0, de_bundle[0]}, 64'd0);
    chk("rst_regwr", {63'b0, de_bundle[22]}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    tick(); tick();
    chk("rst_valid2", {63'b0, de_bundle[0]}, 64'd0);
    chk("rst_pc", de_bundle[293:230], 64'h1000);
    reset_n = 1'b1; wb_reg_write = 1'b0;
    tick();
    chk("x5_after_rst", de_bundle[229:166], 64'd0);
    chk("x5_valid", {63'b0, de_bundle[0]}, 64'd1);

    // Bypass: add x4,x3,x3 with x3 written this cycle
    if_instr = 32'h0031_8233; wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234;
    #1;
    chk("byp_rs1", de_bundle[229:166], 64'h1234);
    chk("byp_rs2", de_bundle[165:102], 64'h1234);
    chk("byp_alu", {60'b0, de_bundle[12:9]}, 64'd0);
    chk("byp_regwr", {63'b0, de_bundle[22]}, 64'd1);
    chk("byp_rd", {59'b0, de_bundle[37:33]}, 64'd4);
    tick();
    wb_reg_write = 1'b0;
    #1;
    chk("array_rs1", de_bundle[229:166], 64'h1234);

    // x0: discarded write, then addi x1,x0,-1
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF; if_instr = 32'hFFF0_0093;
    #1;
    chk("x0_byp", de_bundle[229:166], 64'd0);
    tick();
    wb_reg_write = 1'b0;
    #1;
    chk("x0_rs1", de_bundle[229:166], 64'd0);
    chk("addi_imm", de_bundle[101:38], 64'hFFFF_FFFF_FFFF_FFFF);
    // rs2 field (31) is not an operand of addi: no stall
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd31;
    #1;
    chk("addi_no_rs2_stall", {63'b0, stall}, 64'd0);
    ex_rd = 5'd0;
    #1;
    chk("rd0_no_stall", {63'b0, stall}, 64'd0);

    // Load-use: sw x7,8(x2)
    ex_rd = 5'd7; if_instr = 32'h0071_2423;
    #1;
    chk("lu_stall", {63'b0, stall}, 64'd1);
    chk("lu_valid", {63'b0, de_bundle[0]}, 64'd0);
    chk("lu_memwr", {63'b0, de_bundle[20]}, 64'd0);
    // Writeback to x7 in the same cycle does not cancel the stall
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    #1;
    chk("lu_wb_stall", {63'b0, stall}, 64'd1);
    chk("lu_wb_valid", {63'b0, de_bundle[0]}, 64'd0);
    tick();
    wb_reg_write = 1'b0; ex_valid = 1'b0;
    #1;
    chk("lu2_stall", {63'b0, stall}, 64'd0);
    chk("lu2_memwr", {63'b0, de_bundle[20]}, 64'd1);
    chk("lu2_imm", de_bundle[101:38], 64'd8);
    chk("lu2_rs2data", de_bundle[165:102], 64'h77);
    chk("lu2_valid", {63'b0, de_bundle[0]}, 64'd1);

    // Flush beats stall
    ex_valid = 1'b1; branch_flush = 1'b1;
    #1;
    chk("fl_stall", {63'b0, stall}, 64'd0);
    chk("fl_valid", {63'b0, de_bundle[0]}, 64'd0);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;

    // Illegal opcode, masked by flush, then unmasked
    if_instr = 32'h0000_007F; if_pc = 64'h2468;
    #1;
    chk("ill_flushed", {63'b0, illegal}, 64'd0);
    branch_flush = 1'b0;
    #1;
    chk("ill", {63'b0, illegal}, 64'd1);
    chk("ill_valid", {63'b0, de_bundle[0]}, 64'd0);
    chk("ill_pc", de_bundle[293:230], 64'h2468);
    if_valid = 1'b0;
    #1;
    chk("ill_notvalid", {63'b0, illegal}, 64'd0);
    if_valid = 1'b1;

    // jal x1,-4
    if_instr = 32'hFFDF_F0EF;
    #1;
    chk("jal_imm", de_bundle[101:38], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_bit", {63'b0, de_bundle[17]}, 64'd1);
    chk("jal_rd", {59'b0, de_bundle[37:33]}, 64'd1);

    // srai x5,x6,63: 6-bit shamt, SRA
    if_instr = 32'h43F3_5293;
    #1;
    chk("srai_imm", de_bundle[101:38], 64'd63);
    chk("srai_alu", {60'b0, de_bundle[12:9]}, 64'd7);
    chk("srai_ill", {63'b0, illegal}, 64'd0);

    // lui x2,0x80000: sign-extended U immediate
    if_instr = 32'h8000_0137;
    #1;
    chk("lui_imm", de_bundle[101:38], 64'hFFFF_FFFF_8000_0000);
    chk("lui_alu", {60'b0, de_bundle[12:9]}, 64'd10);
    chk("lui_bit", {63'b0, de_bundle[14]}, 64'd1);

    // subw x8,x9,x10
    if_instr = 32'h40A4_843B;
    #1;
    chk("subw_alu", {60'b0, de_bundle[12:9]}, 64'd1);
    chk("subw_word", {63'b0, de_bundle[1]}, 64'd1);
    chk("subw_rs2", {59'b0, de_bundle[27:23]}, 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
